adder_cpa_pipe: RTL and testbench

ADDER_CPA_PIPE -- requirements
Module: adder_cpa_pipe

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_slice.sv | 23 ++
 rtl/adder_cpa_pipe.sv | 120 ++++++++++++
 tb/tb_adder_cpa_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-propagate adder: operation
// encoding and default geometry.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADDER_WIDTH  = 32;
  localparam int ADDER_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder: one slice of the pipelined adder.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[W];

endmodule

// File: rtl/adder_cpa_pipe.sv
// Pipelined add/subtract with one SLICE-bit ripple slice per stage and a
// valid/ready stream interface. Defining ADDER_OVF_EN adds the signed-overflow output ovf.
module adder_cpa_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_geometry
    $error("adder_cpa_pipe: WIDTH must be a multiple of STAGES");
  end

  logic en;
  logic accept;
  logic is_sub;

  // One register set per stage. Operands travel whole; bits already consumed
  // have no reader downstream and are trimmed away by synthesis.
  logic             v_reg [STAGES];
  logic             c_reg [STAGES];
  logic [WIDTH-1:0] a_reg [STAGES];
  logic [WIDTH-1:0] b_reg [STAGES];
  logic [WIDTH-1:0] s_reg [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;
  assign accept   = in_valid && in_ready;
  assign is_sub   = (op_e'(op) == OP_SUB);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             v_src;
    logic             c_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic [WIDTH-1:0] s_next;
    logic [SLICE-1:0] s_slice;
    logic             co_slice;

    if (gi == 0) begin : g_head
      // Subtract is a + ~b + 1; b is inverted once here and the inverted
      // value is what later stages and the overflow check see.
      assign v_src = accept;
      assign a_src = a;
      assign b_src = is_sub ? ~b : b;
      assign c_src = is_sub ? 1'b1 : cin;
      assign s_src = '0;
    end else begin : g_body
      assign v_src = v_reg[gi-1];
      assign a_src = a_reg[gi-1];
      assign b_src = b_reg[gi-1];
      assign c_src = c_reg[gi-1];
      assign s_src = s_reg[gi-1];
    end

    adder_slice #(
      .W(SLICE)
    ) u_slice (
      .a (a_src[gi*SLICE +: SLICE]),
      .b (b_src[gi*SLICE +: SLICE]),
      .ci(c_src),
      .s (s_slice),
      .co(co_slice)
    );

    always_comb begin
      s_next = s_src;
      s_next[gi*SLICE +: SLICE] = s_slice;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg[gi] <= 1'b0;
        c_reg[gi] <= 1'b0;
        a_reg[gi] <= '0;
        b_reg[gi] <= '0;
        s_reg[gi] <= '0;
      end else if (en) begin
        v_reg[gi] <= v_src;
        c_reg[gi] <= co_slice;
        a_reg[gi] <= a_src;
        b_reg[gi] <= b_src;
        s_reg[gi] <= s_next;
      end
    end
  end

  assign out_valid = v_reg[LAST];
  assign sum       = s_reg[LAST];
  assign cout      = c_reg[LAST];

`ifdef ADDER_OVF_EN
  // Operand MSBs ride along with the beat, so ovf is a pure function of the
  // last stage's registers and stays stable while the output is stalled.
  assign ovf = (a_reg[LAST][WIDTH-1] == b_reg[LAST][WIDTH-1]) &&
               (s_reg[LAST][WIDTH-1] != a_reg[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_adder_cpa_pipe.sv
// Scoreboard bench for adder_cpa_pipe: directed corner beats, stall and reset
// scenarios, then a long random stream checked against an arithmetic model.
module tb_adder_cpa_pipe;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  adder_cpa_pipe #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks    = 0;
  int   passed    = 0;
  int   out_count = 0;
  int   accepted  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: plain integer arithmetic; subtract carry means "no borrow";
  // overflow means the true signed result does not fit in W bits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic o);
    exp_t            e;
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint          sr;
    logic [63:0]     full;
    if (!o) begin
      full   = ux + uy + c;
      e.sum  = full[W-1:0];
      e.cout = full[W];
      sr     = sx + sy + c;
    end else begin
      e.sum  = x - y;
      e.cout = (x >= y);
      sr     = sx - sy;
    end
    e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  // Drive one cycle at the falling edge and record the beat if it is taken.
  task automatic drive(input logic v, input logic ordy, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic cc, input logic oo);
    @(negedge clk);
    out_ready = ordy;
    in_valid  = v;
    a         = aa;
    b         = bb;
    cin       = cc;
    op        = oo;
    #1;
    if (in_valid && in_ready) begin
      q.push_back(model(aa, bb, cc, oo));
      accepted++;
    end
  endtask

  task automatic drive_rand(input logic v, input logic ordy);
    drive(v, ordy, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      drive_rand(1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops one expectation per output handshake; also checks that a
  // stalled output does not change or disappear.
  initial begin : monitor
    exp_t         e;
    logic         hold_pending = 1'b0;
    logic [W-1:0] held_sum     = '0;
    logic         held_cout    = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_pending = 1'b0;
        continue;
      end
      if (hold_pending) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        if (out_valid) begin
          chk("hold_sum", 64'(sum), 64'(held_sum));
          chk("hold_cout", 64'(cout), 64'(held_cout));
        end
      end
      hold_pending = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          out_count++;
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output actual sum=%0h required=no output", sum);
          end else begin
            e = q.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("cout", 64'(cout), 64'(e.cout));
`ifdef ADDER_OVF_EN
            chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
          end
        end else begin
          hold_pending = 1'b1;
          held_sum     = sum;
          held_cout    = cout;
        end
      end
    end
  end

  initial begin : stimulus
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Wrap-around add and exact latency
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      k++;
      #3;
    end while (!out_valid && k < 20);
    chk("latency", 64'(k), 64'(S));
    chk("wrap_sum", 64'(sum), 64'd0);
    chk("wrap_cout", 64'(cout), 64'd1);
    drain(20);

    // Subtract with borrow, signed overflow corners, carry-in path
    drive(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    drain(20);

    // Eight back-to-back beats, consumer stalls in cycles 5..7
    for (int c = 0; c < 16; c++) begin
      drive_rand(c < 8, !(c >= 5 && c <= 7));
      if (c >= 5 && c <= 7) chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    drain(20);

    // Reset with three beats in flight: nothing may emerge afterwards
    for (int c = 0; c < 3; c++) drive_rand(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    out_count = 0;
    @(negedge clk);
    #3;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) drive_rand(1'b0, 1'b1);
    chk("no_stale_output", 64'(out_count), 64'd0);

    // Long random stream with random bubbles and back-pressure
    accepted = 0;
    for (int c = 0; c < 40000 && accepted < 10000; c++)
      drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    chk("random_beats_accepted", 64'(accepted), 64'd10000);
    drain(100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
